// File: rtl/pdm_decimator.sv
// pdm_decimator: PDM mic clocking, boxcar decimation to unsigned PCM, valid/ready output with overrun flag
module pdm_decimator #(
    parameter int WORD_LENGTH    = 16,
    parameter int CLOCK_DIVIDE   = 50,
    parameter int DECIMATION     = 64,
    parameter int SETTLE_WINDOWS = 4
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   enable_i,
    input  logic                   pdm_data_i,
    output logic                   pdm_clk_o,
    output logic [WORD_LENGTH-1:0] sample_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   active_o,
    output logic                   overrun_o
);
    localparam int LOG = $clog2(DECIMATION);
    localparam int DW  = $clog2(CLOCK_DIVIDE);
    localparam int SW  = SETTLE_WINDOWS > 1 ? $clog2(SETTLE_WINDOWS) : 1;
    typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;
    state_t state, state_nxt;
    logic [1:0] sync;
    logic [DW-1:0] div_cnt, div_nxt;
    logic [LOG-1:0] bit_cnt;
    logic [LOG:0] ones, total;
    logic [SW-1:0] settle_cnt;
    logic [WORD_LENGTH-1:0] sample_val;
    logic strobe, done, last_settle, publish;
    always_comb begin
        strobe      = state != IDLE && enable_i && div_cnt == DW'(CLOCK_DIVIDE - 1);
        done        = strobe && bit_cnt == LOG'(DECIMATION - 1);
        total       = ones + (LOG + 1)'(sync[1]);
        sample_val  = total[LOG] ? '1 : WORD_LENGTH'(total[LOG-1:0]) << (WORD_LENGTH - LOG);
        last_settle = settle_cnt == SW'(SETTLE_WINDOWS - 1);
        publish     = done && state == RUN;
        state_nxt   = state;
        if (!enable_i)
            state_nxt = IDLE;
        else if (state == IDLE)
            state_nxt = (SETTLE_WINDOWS == 0) ? RUN : SETTLE;
        else if (state == SETTLE && done && last_settle)
            state_nxt = RUN;
        div_nxt = (state == IDLE || state_nxt == IDLE || div_cnt == DW'(CLOCK_DIVIDE - 1)) ? '0 : div_cnt + DW'(1);
    end
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            sync       <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            ones       <= '0;
            settle_cnt <= '0;
            pdm_clk_o  <= 1'b0;
            sample_o   <= '0;
            valid_o    <= 1'b0;
            active_o   <= 1'b0;
            overrun_o  <= 1'b0;
        end else begin
            sync      <= {sync[0], pdm_data_i};
            div_cnt   <= div_nxt;
            pdm_clk_o <= div_nxt >= DW'(CLOCK_DIVIDE / 2);
            active_o  <= state_nxt == RUN;
            if (state == IDLE || state_nxt == IDLE) begin
                ones       <= '0;
                bit_cnt    <= '0;
                settle_cnt <= '0;
            end else if (strobe) begin
                ones    <= done ? '0 : total;
                bit_cnt <= bit_cnt + LOG'(1);
                if (done && state == SETTLE)
                    settle_cnt <= settle_cnt + SW'(1);
            end
            if (state == IDLE && state_nxt != IDLE)
                overrun_o <= 1'b0;
            if (state_nxt == IDLE)
                valid_o <= 1'b0;
            else if (publish) begin
                sample_o <= sample_val;
                valid_o  <= 1'b1;
                if (valid_o && !ready_i)
                    overrun_o <= 1'b1;
            end else if (valid_o && ready_i)
                valid_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pdm_decimator.sv
// tb_pdm_decimator: table-driven windows checked through a scoreboard, plus timing/handshake/reset sequences
module tb_pdm_decimator;
    typedef struct {
        int          mode;
        logic [15:0] want;
    } vec_t;
    logic clock_i = 1'b0, reset_i = 1'b0, enable_i = 1'b0, pdm_data_i = 1'b0, ready_i = 1'b0;
    logic pdm_clk_o, valid_o, active_o, overrun_o;
    logic [15:0] sample_o;
    int cyc = 0, t0 = 0, total_n = 0, bad_n = 0, acc = 0, p = 0, w = 0;
    bit mon_en = 1'b0;
    vec_t tbl[8];
    vec_t mq[$];
    logic [15:0] sb[$];

    pdm_decimator #(.WORD_LENGTH(16), .CLOCK_DIVIDE(8), .DECIMATION(64), .SETTLE_WINDOWS(1)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .pdm_data_i(pdm_data_i),
        .pdm_clk_o(pdm_clk_o), .sample_o(sample_o), .valid_o(valid_o), .ready_i(ready_i),
        .active_o(active_o), .overrun_o(overrun_o)
    );

    always #5 clock_i = ~clock_i;
    always @(posedge clock_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total_n++;
        if (got !== want) begin
            bad_n++;
            $display("FAIL %s: got %0h expected %0h (idx %0d)", name, got, want, cyc - t0);
        end
    endtask

    function automatic logic bitv(input int mode, input int pos);
        case (mode)
            1: return 1'b1;
            2: return pos % 2 == 0;
            3: return pos < 48;
            4: return pos < 16;
            5: return pos == 37;
            6: return pos != 5;
            default: return 1'b0;
        endcase
    endfunction

    task automatic go_enable();
        @(negedge clock_i);
        enable_i = 1'b1;
        t0 = cyc + 1;
    endtask

    task automatic wait_idx(input int n);
        while (cyc - t0 < n) @(negedge clock_i);
    endtask

    task automatic wait_valid(input int lim);
        while (!valid_o && cyc - t0 < lim) @(negedge clock_i);
    endtask

    initial begin
        vec_t cur;
        cur.mode = 0;
        cur.want = 16'h0000;
        forever begin
            @(posedge pdm_clk_o);
            #1;
            if (p == 0) begin
                if (mq.size() > 0) cur = mq.pop_front();
                else begin
                    cur.mode = 0;
                    cur.want = 16'h0000;
                end
                if (w >= 1 && mon_en) sb.push_back(cur.want);
            end
            pdm_data_i = bitv(cur.mode, p);
            p++;
            if (p == 64) begin
                p = 0;
                w++;
            end
        end
    end

    always @(negedge clock_i) begin
        if (mon_en && valid_o && ready_i) begin
            if (sb.size() == 0) begin
                total_n++;
                bad_n++;
                $display("FAIL sb_empty: got sample %0h with nothing expected", sample_o);
            end else chk("sb_sample", {16'h0, sample_o}, {16'h0, sb.pop_front()});
            acc++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t s;
        bit seen_clk;
        tbl[0] = '{1, 16'hFFFF};
        tbl[1] = '{1, 16'hFFFF};
        tbl[2] = '{0, 16'h0000};
        tbl[3] = '{2, 16'h8000};
        tbl[4] = '{3, 16'hC000};
        tbl[5] = '{4, 16'h4000};
        tbl[6] = '{5, 16'h0400};
        tbl[7] = '{6, 16'hFC00};
        repeat (3) @(negedge clock_i);
        chk("rst_pdm_clk", pdm_clk_o, 0);
        chk("rst_sample", sample_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_active", active_o, 0);
        chk("rst_overrun", overrun_o, 0);
        reset_i = 1'b1;
        repeat (10) @(negedge clock_i);
        chk("idle_active", active_o, 0);
        chk("idle_pdm_clk", pdm_clk_o, 0);

        s = '{1, 16'h0000};
        mq.push_back(s);
        foreach (tbl[i]) mq.push_back(tbl[i]);
        ready_i = 1'b1;
        mon_en = 1'b1;
        go_enable();
        for (int i = 0; i < 16; i++) begin
            @(negedge clock_i);
            chk("pdm_clk_phase", pdm_clk_o, ((cyc - t0) % 8) >= 4);
        end
        while (!active_o && cyc - t0 < 600) @(negedge clock_i);
        chk("active_latency", cyc - t0, 512);
        wait_valid(1100);
        chk("first_valid", cyc - t0, 1024);
        @(negedge clock_i);
        wait_valid(1600);
        chk("second_valid", cyc - t0, 1536);
        while (acc < 8 && cyc - t0 < 6000) @(negedge clock_i);
        chk("accepted_count", acc, 8);
        mon_en = 1'b0;
        enable_i = 1'b0;
        repeat (4) @(negedge clock_i);

        p = 0;
        w = 0;
        mq.delete();
        sb.delete();
        mq.push_back('{0, 16'h0000});
        mq.push_back('{1, 16'hFFFF});
        mq.push_back('{0, 16'h0000});
        mq.push_back('{3, 16'hC000});
        mq.push_back('{2, 16'h8000});
        ready_i = 1'b0;
        go_enable();
        wait_valid(1100);
        chk("b_first_valid", cyc - t0, 1024);
        chk("b_first_sample", sample_o, 16'hFFFF);
        wait_idx(1535);
        chk("b_hold_valid", valid_o, 1);
        chk("b_hold_sample", sample_o, 16'hFFFF);
        ready_i = 1'b1;
        @(negedge clock_i);
        ready_i = 1'b0;
        chk("b_swap_valid", valid_o, 1);
        chk("b_swap_sample", sample_o, 16'h0000);
        chk("b_swap_overrun", overrun_o, 0);
        wait_idx(2047);
        chk("b_pre_overrun", overrun_o, 0);
        @(negedge clock_i);
        chk("b_ovr_valid", valid_o, 1);
        chk("b_ovr_sample", sample_o, 16'hC000);
        chk("b_ovr_flag", overrun_o, 1);
        wait_idx(2050);
        ready_i = 1'b1;
        @(negedge clock_i);
        ready_i = 1'b0;
        chk("b_accept_valid", valid_o, 0);
        chk("b_sticky_overrun", overrun_o, 1);
        wait_idx(2300);
        chk("b_pre_dis_clk", pdm_clk_o, 1);
        chk("b_pre_dis_active", active_o, 1);
        enable_i = 1'b0;
        @(negedge clock_i);
        chk("dis_pdm_clk", pdm_clk_o, 0);
        chk("dis_valid", valid_o, 0);
        chk("dis_active", active_o, 0);
        chk("dis_overrun_hold", overrun_o, 1);
        repeat (3) @(negedge clock_i);

        p = 0;
        w = 0;
        mq.delete();
        mq.push_back('{2, 16'h8000});
        mq.push_back('{1, 16'hFFFF});
        go_enable();
        @(negedge clock_i);
        chk("c_overrun_cleared", overrun_o, 0);
        wait_valid(1100);
        chk("c_first_valid", cyc - t0, 1024);
        chk("c_first_sample", sample_o, 16'hFFFF);
        wait_idx(1028);
        chk("c_pre_rst_clk", pdm_clk_o, 1);
        chk("c_pre_rst_valid", valid_o, 1);
        #2;
        reset_i = 1'b0;
        enable_i = 1'b0;
        #1;
        chk("arst_pdm_clk", pdm_clk_o, 0);
        chk("arst_valid", valid_o, 0);
        chk("arst_active", active_o, 0);
        chk("arst_sample", sample_o, 0);
        chk("arst_overrun", overrun_o, 0);
        @(negedge clock_i);
        reset_i = 1'b1;
        seen_clk = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock_i);
            seen_clk |= pdm_clk_o;
        end
        chk("post_rst_idle_clk", seen_clk, 0);
        chk("post_rst_idle_active", active_o, 0);
        go_enable();
        wait_idx(4);
        chk("re_enable_clk", pdm_clk_o, 1);
        chk("re_enable_settle", active_o, 0);
        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end
endmodule

// File: doc/pdm_decimator.md
Name: pdm_decimator

Overview:
- Front-end capture stage between the PDM microphone pins and clip memory.
- Generates the microphone clock and synchronizes the 1-bit PDM stream.
- Decimates the stream into unsigned WORD_LENGTH-bit PCM samples using a boxcar ones-count (first-order CIC).
- Presents each sample on a valid/ready handshake to the memory write path; the PWM serializer plays back the same unsigned format.

Parameters:
WORD_LENGTH, 16, PCM sample width in bits.
CLOCK_DIVIDE, 50, system cycles per pdm_clk_o period; even, >= 8.
DECIMATION, 64, PDM bits per PCM sample; power of 2, 2..2^WORD_LENGTH.
SETTLE_WINDOWS, 4, decimation windows discarded after enable (mic start-up); 0 allowed.

Ports:
clock_i  in  1  system clock; all logic on rising edge.
reset_i  in  1  asynchronous, active-low reset.
enable_i  in  1  level; 1 = capture, 0 = idle.
pdm_data_i  in  1  raw microphone data, asynchronous to clock_i.
pdm_clk_o  out  1  microphone clock.
sample_o  out  WORD_LENGTH  PCM sample; valid while valid_o = 1.
valid_o  out  1  sample available.
ready_i  in  1  consumer accepts the sample when valid_o & ready_i.
active_o  out  1  1 in RUN state.
overrun_o  out  1  sticky; an unaccepted sample was overwritten.

Behaviour:
- Reset (reset_i = 0, async): state IDLE; all counters and the accumulator cleared; pdm_clk_o = 0; sample_o = 0; valid_o = 0; active_o = 0; overrun_o = 0.
- pdm_data_i synchronizer: 2-flop, reset to 0. Bits are always taken from the synchronized value.
- Divider div_cnt (0..CLOCK_DIVIDE-1):
  - Runs only outside IDLE and starts at 0 on leaving IDLE.
  - pdm_clk_o = 0 for div_cnt < CLOCK_DIVIDE/2, 1 otherwise. pdm_clk_o is a registered output.
  - Bit strobe fires on the cycle div_cnt == CLOCK_DIVIDE-1, i.e. the last high cycle, when data has been stable since the rising edge.
- Per strobe:
  - ones += bit; bit_cnt increments (0..DECIMATION-1).
  - On the strobe with bit_cnt == DECIMATION-1, the window completes. The window total includes the current bit. ones and bit_cnt clear.
- Sample arithmetic:
  - sample = ones_total << (WORD_LENGTH - log2(DECIMATION)).
  - Saturate to 2^WORD_LENGTH-1 when ones_total == DECIMATION.
  - ones width is log2(DECIMATION)+1.
- State machine:
  - IDLE: enable_i = 1 -> SETTLE, or RUN if SETTLE_WINDOWS == 0.
  - SETTLE: counts completed windows and discards them. After SETTLE_WINDOWS windows -> RUN.
  - RUN: each completed window is published.
  - Any state: enable_i = 0 -> IDLE on the next edge. Counters clear, pdm_clk_o = 0, valid_o = 0, and any pending sample is dropped. overrun_o holds its value.
- Publish (cycle after the final strobe): sample_o <= value, valid_o <= 1.
- Handshake:
  - valid_o stays 1 and sample_o stays stable until the cycle valid_o & ready_i, after which valid_o = 0 on the next edge.
  - ready_i is ignored while valid_o = 0.
- Simultaneous accept and publish: old sample accepted, new sample loaded, valid_o stays 1, no overrun.
- Publish while valid_o = 1 & ready_i = 0: new sample overwrites the old one, valid_o stays 1, overrun_o <= 1.
- overrun_o clears only on reset or on an IDLE->SETTLE/RUN transition.
- active_o is registered and equals (state == RUN).
- Latency:
  - First valid_o after enable: (SETTLE_WINDOWS+1)·DECIMATION·CLOCK_DIVIDE cycles.
  - Steady state: one sample per DECIMATION·CLOCK_DIVIDE cycles.

Test Plan (CLOCK_DIVIDE=8, DECIMATION=64, SETTLE_WINDOWS=1, WORD_LENGTH=16):
1. reset_i = 0 mid-run, with pdm_clk_o high and valid_o = 1 -> all outputs 0 immediately, without waiting for a clock edge. After release, stays IDLE until enable_i.
2. pdm_data_i = 1 constant, ready_i = 1, enable_i rises at cycle 0:
   - pdm_clk_o period = 8 cycles, with 4 low then 4 high.
   - active_o = 1 after 512 cycles.
   - First valid_o at cycle 1024, sample_o = 0xFFFF (saturated).
   - Next valid_o at cycle 1536.
3. pdm_data_i = 0 -> sample 0x0000. Alternating 1,0 per pdm_clk_o period -> 32 ones -> 0x8000. 48 ones then 16 zeros -> 0xC000.
4. ready_i = 0 across two publishes -> valid_o held, sample_o equals the second window's value, overrun_o = 1. Then ready_i = 1 for 1 cycle -> valid_o = 0, overrun_o stays 1.
5. ready_i asserted on the exact publish cycle of the next window -> valid_o stays 1, new value appears, overrun_o stays 0.
6. enable_i = 0 midway through a window -> next cycle: pdm_clk_o = 0, valid_o = 0, active_o = 0. Re-enable -> SETTLE repeats, first sample again 1024 cycles later, overrun_o cleared.
